// File: rtl/pc_sequencer.sv
// Sequential program counter: BOOT/RUN/HALT control, prioritised trap and branch
// redirects with misalignment detection, and a fetch handshake that gates sequential advance.
module pc_sequencer #(
  parameter int unsigned    N            = 32,
  parameter logic [N-1:0]   RESET_VECTOR = 32'h0000_0000,
  parameter logic [N-1:0]   TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned    STEP         = 4,
  parameter int unsigned    ALIGN_BITS   = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         fetch_ready,
  input  logic         branch_taken,
  input  logic [N-1:0] branch_target,
  input  logic         trap_req,
  input  logic [N-1:0] trap_target,
  input  logic         halt_req,
  input  logic         resume,
  output logic [N-1:0] pc,
  output logic         pc_valid,
  output logic [N-1:0] pc_next_seq,
  output logic         halted,
  output logic         misaligned,
  output logic [N-1:0] bad_addr
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  localparam logic [N-1:0] STEP_N     = N'(STEP);
  localparam logic [N-1:0] ALIGN_MASK = ~((N'(1) << ALIGN_BITS) - N'(1));

  state_e       state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [N-1:0] bad_addr_q, bad_addr_d;
  logic         misaligned_q, misaligned_d;

  logic [N-1:0] pc_seq;
  logic         fire;
  logic         br_misaligned;

  assign pc_seq        = pc_q + STEP_N;
  assign pc_valid      = (state_q == RUN);
  assign fire          = pc_valid & fetch_ready & ~stall;
  assign br_misaligned = |branch_target[ALIGN_BITS-1:0];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    bad_addr_d   = bad_addr_q;
    misaligned_d = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        // Redirects squash the current fetch, so they ignore stall and fetch_ready.
        if (trap_req) begin
          pc_d = trap_target & ALIGN_MASK;
        end else if (branch_taken && !br_misaligned) begin
          pc_d = branch_target;
        end else if (branch_taken) begin
          pc_d         = TRAP_VECTOR;
          bad_addr_d   = branch_target;
          misaligned_d = 1'b1;
        end else if (fire) begin
          pc_d = pc_seq;
        end
        if (halt_req) state_d = HALT;
      end
      HALT: begin
        if (trap_req) pc_d = trap_target & ALIGN_MASK;
        if (resume && !halt_req) state_d = RUN;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VECTOR;
      bad_addr_q   <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      bad_addr_q   <= bad_addr_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign pc          = pc_q;
  assign pc_next_seq = pc_seq;
  assign halted      = (state_q == HALT);
  assign misaligned  = misaligned_q;
  assign bad_addr    = bad_addr_q;

endmodule
